// File: rtl/mc_chroma_interp_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mc_chroma_interp_pipe
//  Purpose  : Separable 4-tap chroma motion-compensation interpolator.
//             Streams blk_h+3 source rows through a horizontal filter and
//             keeps three filtered rows in a shift buffer. Every row after
//             the third closes a 4-row vertical window and produces one
//             output row of LANES clipped pixels.
//  Ports    : clk, rstn        - clock, asynchronous active-low reset
//             start, frac_x/y,
//             blk_h            - block command, latched in IDLE only
//             in_valid/ready,
//             in_row           - source row stream, LANES+3 pixels per row
//             out_valid/ready,
//             out_pel, out_last- filtered row stream, last row flagged
//             out_val          - unclipped vertical result per lane
//                                (only with MC_CHROMA_INTERP_BIPRED_EN)
//             busy, done       - block status, done pulses after last row
//  Config   : `define MC_CHROMA_INTERP_BIPRED_EN adds the out_val port.
//  Revision : 1.0 - initial release
// ============================================================================
module mc_chroma_interp_pipe #(
    parameter int BIT_DEPTH = 8,
    parameter int LANES     = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             start,
    input  logic [2:0]                       frac_x,
    input  logic [2:0]                       frac_y,
    input  logic [5:0]                       blk_h,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [(LANES+3)*BIT_DEPTH-1:0]   in_row,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES*BIT_DEPTH-1:0]       out_pel,
    output logic                             out_last,
`ifdef MC_CHROMA_INTERP_BIPRED_EN
    output logic [LANES*16-1:0]              out_val,
`endif
    output logic                             busy,
    output logic                             done
);

    localparam int                      H_SHIFT = BIT_DEPTH - 8;
    localparam int                      O_SHIFT = 14 - BIT_DEPTH;
    localparam logic signed [23:0]      ROUND   = 24'(1 << (13 - BIT_DEPTH));
    localparam logic signed [23:0]      PEL_MAX = 24'((1 << BIT_DEPTH) - 1);
    localparam logic [BIT_DEPTH-1:0]    PEL_ONES = '1;

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    // Four taps {A,B,C,D} packed MSB-first, one signed byte each.
    function automatic logic [31:0] taps(input logic [2:0] ph);
        logic [31:0] t;
        case (ph)
            3'd0:    t = { 8'sd0,  8'sd64,  8'sd0,   8'sd0};
            3'd1:    t = {-8'sd2,  8'sd58,  8'sd10, -8'sd2};
            3'd2:    t = {-8'sd4,  8'sd54,  8'sd16, -8'sd2};
            3'd3:    t = {-8'sd6,  8'sd46,  8'sd28, -8'sd4};
            3'd4:    t = {-8'sd4,  8'sd36,  8'sd36, -8'sd4};
            3'd5:    t = {-8'sd4,  8'sd28,  8'sd46, -8'sd6};
            3'd6:    t = {-8'sd2,  8'sd16,  8'sd54, -8'sd4};
            default: t = {-8'sd2,  8'sd10,  8'sd58, -8'sd2};
        endcase
        return t;
    endfunction

    state_t                    state;
    logic [2:0]                fx_q;
    logic [2:0]                fy_q;
    logic [5:0]                bh_q;
    logic [5:0]                rows_in;
    // hb0 holds the oldest filtered row of the window, hb2 the newest.
    logic [LANES*16-1:0]       hb0, hb1, hb2;
    logic [LANES*16-1:0]       h_cur;
    logic [LANES*BIT_DEPTH-1:0] pel_nxt;
`ifdef MC_CHROMA_INTERP_BIPRED_EN
    logic [LANES*16-1:0]       val_nxt;
`endif

    logic [31:0]               hx_taps, vy_taps;
    logic signed [31:0]        ha, hb, hc, hd;
    logic signed [23:0]        va, vb, vc, vd;
    logic                      row_acc;
    logic                      last_row;

    assign hx_taps = taps(fx_q);
    assign vy_taps = taps(fy_q);
    assign ha = {{24{hx_taps[31]}}, hx_taps[31:24]};
    assign hb = {{24{hx_taps[23]}}, hx_taps[23:16]};
    assign hc = {{24{hx_taps[15]}}, hx_taps[15:8]};
    assign hd = {{24{hx_taps[7]}},  hx_taps[7:0]};
    assign va = {{16{vy_taps[31]}}, vy_taps[31:24]};
    assign vb = {{16{vy_taps[23]}}, vy_taps[23:16]};
    assign vc = {{16{vy_taps[15]}}, vy_taps[15:8]};
    assign vd = {{16{vy_taps[7]}},  vy_taps[7:0]};

    // Accepting is only possible in FILL/RUN; in RUN the output register
    // must be free (or draining this cycle) because each row yields a result.
    assign in_ready = (state == FILL) || ((state == RUN) && (!out_valid || out_ready));
    assign row_acc  = in_valid && in_ready;
    // Row index blk_h+2 (0-based) is the final source row of the block.
    assign last_row = (rows_in == bh_q + 6'd2);
    assign busy     = (state != IDLE);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [31:0] p0, p1, p2, p3;
        logic signed [31:0] hsum;
        logic signed [23:0] r0, r1, r2, r3;
        logic signed [23:0] vsum;
        logic signed [23:0] vsh;
        logic signed [23:0] osh;

        assign p0 = {{(32-BIT_DEPTH){1'b0}}, in_row[(k+0)*BIT_DEPTH +: BIT_DEPTH]};
        assign p1 = {{(32-BIT_DEPTH){1'b0}}, in_row[(k+1)*BIT_DEPTH +: BIT_DEPTH]};
        assign p2 = {{(32-BIT_DEPTH){1'b0}}, in_row[(k+2)*BIT_DEPTH +: BIT_DEPTH]};
        assign p3 = {{(32-BIT_DEPTH){1'b0}}, in_row[(k+3)*BIT_DEPTH +: BIT_DEPTH]};

        assign hsum = ha * p0 + hb * p1 + hc * p2 + hd * p3;
        assign h_cur[k*16 +: 16] = 16'(hsum >>> H_SHIFT);

        // Vertical window: three buffered rows plus the row arriving now.
        assign r0 = {{8{hb0[k*16+15]}},   hb0[k*16 +: 16]};
        assign r1 = {{8{hb1[k*16+15]}},   hb1[k*16 +: 16]};
        assign r2 = {{8{hb2[k*16+15]}},   hb2[k*16 +: 16]};
        assign r3 = {{8{h_cur[k*16+15]}}, h_cur[k*16 +: 16]};

        assign vsum = va * r0 + vb * r1 + vc * r2 + vd * r3;
        assign vsh  = vsum >>> 6;
        assign osh  = (vsh + ROUND) >>> O_SHIFT;

        assign pel_nxt[k*BIT_DEPTH +: BIT_DEPTH] =
            (osh < 0)       ? '0 :
            (osh > PEL_MAX) ? PEL_ONES :
                              BIT_DEPTH'(osh);
`ifdef MC_CHROMA_INTERP_BIPRED_EN
        assign val_nxt[k*16 +: 16] = 16'(vsh);
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            fx_q      <= '0;
            fy_q      <= '0;
            bh_q      <= '0;
            rows_in   <= '0;
            hb0       <= '0;
            hb1       <= '0;
            hb2       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_pel   <= '0;
`ifdef MC_CHROMA_INTERP_BIPRED_EN
            out_val   <= '0;
`endif
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            if (row_acc) begin
                hb0     <= hb1;
                hb1     <= hb2;
                hb2     <= h_cur;
                rows_in <= rows_in + 6'd1;
            end

            case (state)
                IDLE: begin
                    if (start && (blk_h != 6'd0)) begin
                        fx_q    <= frac_x;
                        fy_q    <= frac_y;
                        bh_q    <= blk_h;
                        rows_in <= '0;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    if (row_acc && (rows_in == 6'd2)) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (row_acc) begin
                        out_valid <= 1'b1;
                        out_pel   <= pel_nxt;
`ifdef MC_CHROMA_INTERP_BIPRED_EN
                        out_val   <= val_nxt;
`endif
                        out_last  <= last_row;
                        if (last_row) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // out_valid is always set on entry; wait for its handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_chroma_interp_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_chroma_interp_pipe
//  Purpose  : Self-checking bench for mc_chroma_interp_pipe. A reference
//             model computes every expected output row when its last source
//             row is handed over; a monitor pops and compares on handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mc_chroma_interp_pipe;

    localparam int BD = 8;
    localparam int LN = 4;
    localparam int NP = LN + 3;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [2:0]        frac_x = '0;
    logic [2:0]        frac_y = '0;
    logic [5:0]        blk_h = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NP*BD-1:0]  in_row = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [LN*BD-1:0]  out_pel;
    logic              out_last;
    logic              busy;
    logic              done;
`ifdef MC_CHROMA_INTERP_BIPRED_EN
    logic [LN*16-1:0]  out_val;
    logic [LN*16-1:0]  last_val = '0;
`endif

    typedef struct packed {
        logic [LN*BD-1:0] pel;
`ifdef MC_CHROMA_INTERP_BIPRED_EN
        logic [LN*16-1:0] val;
`endif
        logic             last;
    } exp_t;

    exp_t              sb[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                hh[4][LN];
    int                cur[NP];
    int                m_fx = 0;
    int                m_fy = 0;
    logic              exp_done = 1'b0;
    logic [LN*BD-1:0]  last_pel = '0;
    logic              feed_done = 1'b0;

    mc_chroma_interp_pipe #(.BIT_DEPTH(BD), .LANES(LN)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .frac_x    (frac_x),
        .frac_y    (frac_y),
        .blk_h     (blk_h),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pel   (out_pel),
        .out_last  (out_last),
`ifdef MC_CHROMA_INTERP_BIPRED_EN
        .out_val   (out_val),
`endif
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int tap(input int ph, input int i);
        int t[4];
        case (ph)
            0:       t = '{ 0, 64,  0,  0};
            1:       t = '{-2, 58, 10, -2};
            2:       t = '{-4, 54, 16, -2};
            3:       t = '{-6, 46, 28, -4};
            4:       t = '{-4, 36, 36, -4};
            5:       t = '{-4, 28, 46, -6};
            6:       t = '{-2, 16, 54, -4};
            default: t = '{-2, 10, 58, -2};
        endcase
        return t[i];
    endfunction

    // Reference model: filter the row in cur[], slide the window and, once
    // four rows are present, queue the expected output row.
    task automatic model_accept(input int idx, input int bh);
        int   v;
        int   o;
        exp_t e;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < LN; k++) hh[r][k] = hh[r+1][k];
        for (int k = 0; k < LN; k++)
            hh[3][k] = (tap(m_fx,0)*cur[k] + tap(m_fx,1)*cur[k+1] +
                        tap(m_fx,2)*cur[k+2] + tap(m_fx,3)*cur[k+3]) >>> (BD-8);
        if (idx >= 3) begin
            e = '0;
            for (int k = 0; k < LN; k++) begin
                v = (tap(m_fy,0)*hh[0][k] + tap(m_fy,1)*hh[1][k] +
                     tap(m_fy,2)*hh[2][k] + tap(m_fy,3)*hh[3][k]) >>> 6;
                o = (v + (1 << (13-BD))) >>> (14-BD);
                if (o < 0) o = 0;
                if (o > (1 << BD) - 1) o = (1 << BD) - 1;
                e.pel[k*BD +: BD] = 8'(o);
`ifdef MC_CHROMA_INTERP_BIPRED_EN
                e.val[k*16 +: 16] = 16'(v);
`endif
            end
            e.last = (idx == bh + 2);
            sb.push_back(e);
        end
    endtask

    // Monitor: done must follow a last-row handshake by exactly one cycle;
    // every output handshake is checked against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            exp_done = 1'b0;
        end else begin
            n_cmp++;
            if (done !== exp_done) begin
                n_bad++;
                $display("FAIL done_pulse: got %b, required %b at %0t", done, exp_done, $time);
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_row: got out_pel %h, required no output", out_pel);
                end else begin
                    e = sb.pop_front();
                    if (out_pel !== e.pel || out_last !== e.last
`ifdef MC_CHROMA_INTERP_BIPRED_EN
                        || out_val !== e.val
`endif
                       ) begin
                        n_bad++;
                        $display("FAIL row_data: got pel %h last %b, required pel %h last %b",
                                 out_pel, out_last, e.pel, e.last);
                    end
                end
                last_pel = out_pel;
`ifdef MC_CHROMA_INTERP_BIPRED_EN
                last_val = out_val;
`endif
                exp_done = out_last;
            end else begin
                exp_done = 1'b0;
            end
        end
    end

    task automatic feed(input int nrows, input int bh, input int kind);
        for (int i = 0; i < nrows; i++) begin
            bit got;
            got = 1'b0;
            for (int j = 0; j < NP; j++) begin
                case (kind)
                    0:       cur[j] = 16*i + j;
                    1:       cur[j] = 100;
                    2:       cur[j] = ((j % 4 == 1) || (j % 4 == 2)) ? 255 : 0;
                    3:       cur[j] = ((j % 4 == 1) || (j % 4 == 2)) ? 0 : 255;
                    default: cur[j] = int'($urandom_range(0, 255));
                endcase
                in_row[j*BD +: BD] = 8'(cur[j]);
            end
            in_valid = 1'b1;
            for (int c = 0; c < 300 && !got; c++) begin
                @(negedge clk);
                if (in_ready === 1'b1) begin
                    got = 1'b1;
                    model_accept(i, bh);
                end
                @(posedge clk); #1;
            end
            if (!got) begin
                n_cmp++; n_bad++;
                $display("FAIL feed_timeout: row %0d in_ready got 0, required 1", i);
                break;
            end
        end
        in_valid  = 1'b0;
        feed_done = 1'b1;
    endtask

    // mode 0: always ready, 1: random ready, 2: one 5-cycle stall in RUN
    task automatic ready_ctrl(input int mode);
        logic [LN*BD-1:0] held;
        bit               seen;
        held = '0;
        seen = 1'b0;
        if (mode == 1) begin
            for (int c = 0; c < 4000 && !(feed_done && sb.size() == 0); c++) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
        end else if (mode == 2) begin
            for (int c = 0; c < 300 && !seen; c++) begin
                @(negedge clk);
                if (out_valid === 1'b1) seen = 1'b1;
            end
            if (!seen) begin
                n_cmp++; n_bad++;
                $display("FAIL stall_wait: out_valid got 0, required 1");
            end else begin
                @(posedge clk); #1;
                out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                        n_bad++;
                        $display("FAIL stall_flags: got in_ready %b out_valid %b, required 0 1",
                                 in_ready, out_valid);
                    end
                    if (c == 0) begin
                        held = out_pel;
                    end else begin
                        n_cmp++;
                        if (out_pel !== held) begin
                            n_bad++;
                            $display("FAIL stall_hold: got %h, required %h", out_pel, held);
                        end
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        end
    endtask

    task automatic start_block(input int fx, input int fy, input int bh);
        m_fx    = fx;
        m_fy    = fy;
        start   = 1'b1;
        frac_x  = 3'(fx);
        frac_y  = 3'(fy);
        blk_h   = 6'(bh);
        @(posedge clk); #1;
        start   = 1'b0;
        // Scramble the command inputs: the block must use the latched copy.
        frac_x  = ~3'(fx);
        frac_y  = ~3'(fy);
        blk_h   = 6'(bh + 5);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_busy: got %b, required 1", busy);
        end
    endtask

    task automatic run_block(input int fx, input int fy, input int bh,
                             input int kind, input int mode, input bit junk);
        start_block(fx, fy, bh);
        if (junk) begin
            // A start while busy must be ignored.
            start = 1'b1;
            blk_h = 6'd1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        feed_done = 1'b0;
        fork
            feed(bh + 3, bh, kind);
            ready_ctrl(mode);
        join
        for (int c = 0; c < 200 && (sb.size() != 0 || busy !== 1'b0); c++) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL block_end: got %0d rows pending busy %b, required 0 0", sb.size(), busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_last, busy, done} !== 5'b0 || out_pel !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got flags %b pel %h, required 0 0",
                     {in_ready, out_valid, out_last, busy, done}, out_pel);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL after_reset: got busy %b in_ready %b, required 0 0", busy, in_ready);
        end
    endtask

    task automatic test_zero_height();
        start = 1'b1;
        blk_h = 6'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_height: got busy %b, required 0", busy);
        end
    endtask

    task automatic test_full_pel();
        run_block(0, 0, 4, 0, 0, 1'b0);
        n_cmp++;
        if (last_pel !== {8'd68, 8'd67, 8'd66, 8'd65}) begin
            n_bad++;
            $display("FAIL full_pel: got %h, required %h", last_pel, {8'd68, 8'd67, 8'd66, 8'd65});
        end
    endtask

    task automatic test_flat_2d();
        run_block(4, 4, 2, 1, 1, 1'b1);
        n_cmp++;
        if (last_pel !== {4{8'd100}}) begin
            n_bad++;
            $display("FAIL flat_2d: got %h, required %h", last_pel, {4{8'd100}});
        end
    endtask

    task automatic test_clip();
        run_block(4, 0, 2, 2, 0, 1'b0);
        n_cmp++;
        if (last_pel[7:0] !== 8'd255) begin
            n_bad++;
            $display("FAIL clip_high: got %0d, required 255", last_pel[7:0]);
        end
`ifdef MC_CHROMA_INTERP_BIPRED_EN
        n_cmp++;
        if (last_val[15:0] !== 16'd18360) begin
            n_bad++;
            $display("FAIL clip_high_val: got %0d, required 18360", $signed(last_val[15:0]));
        end
`endif
        run_block(4, 0, 2, 3, 0, 1'b0);
        n_cmp++;
        if (last_pel[7:0] !== 8'd0) begin
            n_bad++;
            $display("FAIL clip_low: got %0d, required 0", last_pel[7:0]);
        end
`ifdef MC_CHROMA_INTERP_BIPRED_EN
        n_cmp++;
        if (last_val[15:0] !== -16'sd2040) begin
            n_bad++;
            $display("FAIL clip_low_val: got %0d, required -2040", $signed(last_val[15:0]));
        end
`endif
    endtask

    task automatic test_backpressure();
        run_block(3, 5, 8, 4, 2, 1'b0);
    endtask

    task automatic test_boundary();
        run_block(7, 1, 1, 4, 0, 1'b0);
        run_block(1, 7, 32, 4, 1, 1'b0);
    endtask

    task automatic test_reset_mid_block();
        start_block(2, 6, 8);
        feed_done = 1'b0;
        feed(6, 8, 4);
        rstn = 1'b0;
        #2;
        n_cmp++;
        if ({in_ready, out_valid, out_last, busy, done} !== 5'b0 || out_pel !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: got flags %b pel %h, required 0 0",
                     {in_ready, out_valid, out_last, busy, done}, out_pel);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_idle: got busy %b, required 0", busy);
        end
        run_block(2, 6, 8, 4, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_zero_height();
        test_full_pel();
        test_flat_2d();
        test_clip();
        test_backpressure();
        test_boundary();
        test_reset_mid_block();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
